// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle data-memory / memory-mapped I/O stage.
// Holds the I/O base, register offsets, board port widths, timer reset value
// and the I/O offset decoder used by sc_datamem_io.
package sc_io_pkg;

  localparam logic [23:0] IO_BASE = 24'hFFFFFF;

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_HEX     = 8'h04;
  localparam logic [7:0] OFF_SW      = 8'h08;
  localparam logic [7:0] OFF_KEYFLAG = 8'h0C;
  localparam logic [7:0] OFF_TCOUNT  = 8'h10;
  localparam logic [7:0] OFF_TCMP    = 8'h14;
  localparam logic [7:0] OFF_TCTRL   = 8'h18;

  localparam int LED_W = 10;
  localparam int HEX_W = 24;
  localparam int KEY_W = 4;
  localparam int SW_W  = 10;

  localparam logic [31:0] TCMP_RST = 32'hFFFFFFFF;

  // Target of the current access.
  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_HEX,
    SEL_SW,
    SEL_KEYFLAG,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL
  } sel_e;

  // Decode a word offset (addr[7:2]) inside the I/O page.
  function automatic sel_e io_sel(input logic [5:0] word_off);
    sel_e s;
    s = SEL_NONE;
    if (word_off == OFF_LED[7:2])          s = SEL_LED;
    else if (word_off == OFF_HEX[7:2])     s = SEL_HEX;
    else if (word_off == OFF_SW[7:2])      s = SEL_SW;
    else if (word_off == OFF_KEYFLAG[7:2]) s = SEL_KEYFLAG;
    else if (word_off == OFF_TCOUNT[7:2])  s = SEL_TCOUNT;
    else if (word_off == OFF_TCMP[7:2])    s = SEL_TCMP;
    else if (word_off == OFF_TCTRL[7:2])   s = SEL_TCTRL;
    return s;
  endfunction

endpackage

// File: rtl/sc_io_sync.sv
// Two-flop synchronizer for asynchronous board inputs, with a settable reset value.
// Ports: clock, reset (sync, active-high), d (async in), s1 (first stage), q (second stage).
// Latency: d appears on q after 2 rising edges.
module sc_io_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] s1,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sc_datamem_io.sv
// Data memory plus memory-mapped board I/O for the single-cycle CPU: word RAM,
// LED/HEX registers, synchronized switches, sticky key-press flags, optional timer.
// Ports: clock/reset (sync, active-high), addr/wdata/we from the CPU, rdata (combinational
// load data), sw/key board inputs, led/hex board outputs. Timer present only when
// the macro DMEM_TIMER_EN is defined; otherwise offsets 0x10-0x18 read 0 and ignore writes.
module sc_datamem_io
  import sc_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   sw,
  input  logic [KEY_W-1:0]  key,
  output logic [LED_W-1:0]  led,
  output logic [HEX_W-1:0]  hex
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // Byte lanes are not supported; the low address bits are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^addr[1:0];

  // ---------------- address decode ----------------
  logic                  ram_hit;
  logic                  io_hit;
  logic [DEPTH_LOG2-1:0] ram_idx;
  sel_e                  sel;
  logic                  wr;

  assign ram_hit = (addr[31:DEPTH_LOG2+2] == '0);
  assign io_hit  = (addr[31:8] == IO_BASE);
  assign ram_idx = addr[DEPTH_LOG2+1:2];
  // A write coinciding with reset is dropped everywhere, RAM included.
  assign wr      = we & ~reset;

  always_comb begin
    sel = SEL_NONE;
    if (ram_hit)     sel = SEL_RAM;
    else if (io_hit) sel = io_sel(addr[7:2]);
  end

  // ---------------- word RAM (not reset) ----------------
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr && sel == SEL_RAM) mem[ram_idx] <= wdata;
  end

  // ---------------- output registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      led <= '0;
      hex <= '0;
    end else begin
      if (wr && sel == SEL_LED) led <= wdata[LED_W-1:0];
      if (wr && sel == SEL_HEX) hex <= wdata[HEX_W-1:0];
    end
  end

  // ---------------- switch and key inputs ----------------
  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_s2;
  logic [KEY_W-1:0] key_s1;
  logic [KEY_W-1:0] key_s2;
  logic [KEY_W-1:0] key_s3;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_clr;
  logic [KEY_W-1:0] key_flag;

  sc_io_sync #(.W(SW_W), .RST_VAL('0)) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d     (sw),
    .s1    (sw_s1),
    .q     (sw_s2)
  );

  // Keys are active-low and idle high, so their synchronizer resets to all ones.
  sc_io_sync #(.W(KEY_W), .RST_VAL('1)) u_key_sync (
    .clock (clock),
    .reset (reset),
    .d     (key),
    .s1    (key_s1),
    .q     (key_s2)
  );

  logic unused_sync;
  assign unused_sync = ^{sw_s1, key_s1};

  // Press = high-to-low transition seen between s3 and s2.
  assign key_press = key_s3 & ~key_s2;
  assign key_clr   = (wr && sel == SEL_KEYFLAG) ? wdata[KEY_W-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_s3   <= '1;
      key_flag <= '0;
    end else begin
      key_s3   <= key_s2;
      // A new press in the same cycle as a clear keeps the flag set.
      key_flag <= key_press | (key_flag & ~key_clr);
    end
  end

  // ---------------- compare timer ----------------
`ifdef DMEM_TIMER_EN
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        ten;
  logic        tmatch;
  logic        tmatch_set;
  logic        tmatch_clr;

  assign tmatch_set = ten && (tcount == tcmp);
  assign tmatch_clr = wr && (sel == SEL_TCTRL) && wdata[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= TCMP_RST;
      ten    <= 1'b0;
      tmatch <= 1'b0;
    end else begin
      // CPU write to TCOUNT overrides reload/increment.
      if (wr && sel == SEL_TCOUNT) tcount <= wdata;
      else if (tmatch_set)         tcount <= '0;
      else if (ten)                tcount <= tcount + 32'd1;
      if (wr && sel == SEL_TCMP)   tcmp   <= wdata;
      if (wr && sel == SEL_TCTRL)  ten    <= wdata[0];
      tmatch <= tmatch_set | (tmatch & ~tmatch_clr);
    end
  end
`endif

  // ---------------- load mux ----------------
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_RAM:     rdata = mem[ram_idx];
      SEL_LED:     rdata = {{(32-LED_W){1'b0}}, led};
      SEL_HEX:     rdata = {{(32-HEX_W){1'b0}}, hex};
      SEL_SW:      rdata = {{(32-SW_W){1'b0}}, sw_s2};
      SEL_KEYFLAG: rdata = {{(32-KEY_W){1'b0}}, key_flag};
`ifdef DMEM_TIMER_EN
      SEL_TCOUNT:  rdata = tcount;
      SEL_TCMP:    rdata = tcmp;
      SEL_TCTRL:   rdata = {30'b0, tmatch, ten};
`endif
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sc_datamem_io.sv
module tb_sc_datamem_io;

  localparam int DL2 = 6;
  localparam int NW  = 2 ** DL2;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  led;
  logic [23:0] hex;

  sc_datamem_io #(.DEPTH_LOG2(DL2)) dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .sw    (sw),
    .key   (key),
    .led   (led),
    .hex   (hex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] rd;
    logic [9:0]  led;
    logic [23:0] hex;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  logic [31:0] m_mem [NW];
  logic [9:0]  m_led;
  logic [23:0] m_hex;
  logic [9:0]  m_sw_hist [2];   // [0] sampled last edge, [1] the edge before
  logic [3:0]  m_key_hist [3];  // [k] = key sampled k+1 edges ago
  logic [3:0]  m_flags;
  logic [31:0] m_tcount;
  logic [31:0] m_tcmp;
  logic        m_ten;
  logic        m_tmatch;

  function automatic void model_reset();
    m_led = '0; m_hex = '0; m_flags = '0;
    m_sw_hist[0] = '0; m_sw_hist[1] = '0;
    for (int k = 0; k < 3; k++) m_key_hist[k] = 4'hF;
    m_tcount = '0; m_tcmp = 32'hFFFFFFFF; m_ten = 1'b0; m_tmatch = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    if (a < 32'(4 * NW)) return m_mem[(a / 4) % NW];
    if ((a >> 8) != 32'h00FFFFFF) return 32'h0;
    off = a & 32'hFC;
    case (off)
      32'h00: return 32'(m_led);
      32'h04: return 32'(m_hex);
      32'h08: return 32'(m_sw_hist[1]);
      32'h0C: return 32'(m_flags);
`ifdef DMEM_TIMER_EN
      32'h10: return m_tcount;
      32'h14: return m_tcmp;
      32'h18: return {30'b0, m_tmatch, m_ten};
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge with the given inputs.
  function automatic void model_edge(input logic [31:0] a, input logic [31:0] d,
                                     input logic w, input logic rst,
                                     input logic [9:0] s, input logic [3:0] k);
    logic [3:0]  press;
    logic [3:0]  clr;
    logic        hit;
    logic [31:0] off;
    logic [31:0] next_count;
    logic        set_match;
    if (rst) begin
      model_reset();
      return;
    end
    press = m_key_hist[2] & ~m_key_hist[1];
    m_key_hist[2] = m_key_hist[1];
    m_key_hist[1] = m_key_hist[0];
    m_key_hist[0] = k;
    m_sw_hist[1] = m_sw_hist[0];
    m_sw_hist[0] = s;

    hit = w && ((a >> 8) == 32'h00FFFFFF);
    off = a & 32'hFC;
    clr = (hit && off == 32'h0C) ? d[3:0] : 4'h0;
    m_flags = press | (m_flags & ~clr);

    set_match  = m_ten && (m_tcount == m_tcmp);
    next_count = !m_ten ? m_tcount : (set_match ? 32'h0 : m_tcount + 32'h1);
`ifdef DMEM_TIMER_EN
    if (hit && off == 32'h10) next_count = d;
    if (hit && off == 32'h14) m_tcmp = d;
    m_tmatch = set_match || (m_tmatch && !(hit && off == 32'h18 && d[1]));
    if (hit && off == 32'h18) m_ten = d[0];
`endif
    m_tcount = next_count;

    if (w && a < 32'(4 * NW)) m_mem[(a / 4) % NW] = d;
    if (hit && off == 32'h00) m_led = d[9:0];
    if (hit && off == 32'h04) m_hex = d[23:0];
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, queues the expectation, steps the model.
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic rst, input logic use_c, input logic [31:0] c);
    exp_t e;
    addr = a; wdata = d; we = w; reset = rst;
    e.a   = a;
    e.rd  = use_c ? c : model_read(a);
    e.led = m_led;
    e.hex = m_hex;
    exp_q.push_back(e);
    model_edge(a, d, w, rst, sw, key);
    @(posedge clock); #1;
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] c);
    drive(a, 32'h0, 1'b0, 1'b0, 1'b1, c);
  endtask

  task automatic rd_op(input logic [31:0] a);
    drive(a, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests = tests + 3;
      if (rdata !== e.rd) begin
        fails++;
        $display("FAIL rdata addr=%h got=%h exp=%h t=%0t", e.a, rdata, e.rd, $time);
      end
      if (led !== e.led) begin
        fails++;
        $display("FAIL led got=%h exp=%h t=%0t", led, e.led, $time);
      end
      if (hex !== e.hex) begin
        fails++;
        $display("FAIL hex got=%h exp=%h t=%0t", hex, e.hex, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] off;
    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; sw = '0; key = 4'hF;
    for (int i = 0; i < NW; i++) m_mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;

    // Give every RAM word a known value.
    for (int i = 0; i < NW; i++) wr_op(32'(i * 4), $urandom);

    // RAM store then load, low address bits ignored.
    wr_op(32'h10, 32'h12345678);
    rd_chk(32'h10, 32'h12345678);
    rd_chk(32'h11, 32'h12345678);

    // LED / HEX / SW.
    sw = 10'h155;
    wr_op(32'hFFFFFF00, 32'h000003FF);
    wr_op(32'hFFFFFF04, 32'h00ABCDEF);
    rd_chk(32'hFFFFFF00, 32'h3FF);
    rd_chk(32'hFFFFFF04, 32'hABCDEF);
    wr_op(32'hFFFFFF08, 32'hFFFFFFFF);
    rd_chk(32'hFFFFFF08, 32'h155);

    // Key[2] press: flag visible after 3 edges.
    key = 4'b1011;
    rd_chk(32'hFFFFFF0C, 32'h0);
    rd_chk(32'hFFFFFF0C, 32'h0);
    rd_chk(32'hFFFFFF0C, 32'h0);
    rd_chk(32'hFFFFFF0C, 32'h4);
    // Key[0] press lands on the same edge as the W1C of bit 2.
    key = 4'b1010;
    rd_chk(32'hFFFFFF0C, 32'h4);
    rd_chk(32'hFFFFFF0C, 32'h4);
    wr_op(32'hFFFFFF0C, 32'h4);
    rd_chk(32'hFFFFFF0C, 32'h1);
    key = 4'hF;
    repeat (4) rd_chk(32'hFFFFFF0C, 32'h1);

`ifdef DMEM_TIMER_EN
    wr_op(32'hFFFFFF14, 32'd3);
    wr_op(32'hFFFFFF10, 32'd0);
    wr_op(32'hFFFFFF18, 32'h1);
    rd_chk(32'hFFFFFF10, 32'd0);
    rd_chk(32'hFFFFFF10, 32'd1);
    rd_chk(32'hFFFFFF10, 32'd2);
    rd_chk(32'hFFFFFF10, 32'd3);
    rd_chk(32'hFFFFFF10, 32'd0);
    rd_chk(32'hFFFFFF18, 32'h3);
    wr_op(32'hFFFFFF18, 32'h3);
    rd_chk(32'hFFFFFF18, 32'h1);
    wr_op(32'hFFFFFF18, 32'h0);
`else
    rd_chk(32'hFFFFFF10, 32'h0);
    wr_op(32'hFFFFFF14, 32'd7);
    rd_chk(32'hFFFFFF14, 32'h0);
    wr_op(32'hFFFFFF18, 32'h1);
    rd_chk(32'hFFFFFF18, 32'h0);
`endif

    // Unmapped write/read, and RAM word 0 must not alias it.
    wr_op(32'h80000000, 32'hDEADBEEF);
    rd_chk(32'h80000000, 32'h0);
    rd_op(32'h00000000);
    rd_chk(32'hFFFFFF40, 32'h0);

    // Reset mid-operation with a colliding write that must be dropped.
    drive(32'hFFFFFF00, 32'h155, 1'b1, 1'b1, 1'b0, 32'h0);
    rd_chk(32'hFFFFFF00, 32'h0);
    rd_chk(32'hFFFFFF04, 32'h0);
    rd_chk(32'hFFFFFF0C, 32'h0);
`ifdef DMEM_TIMER_EN
    rd_chk(32'hFFFFFF10, 32'h0);
    rd_chk(32'hFFFFFF14, 32'hFFFFFFFF);
`endif
    rd_chk(32'h10, 32'h12345678);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 25) begin
        wr_op({24'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))} & 32'hFF, d);
      end else if (r < 50) begin
        rd_op(32'($urandom_range(0, 4 * NW - 1)));
      end else if (r < 88) begin
        off = 32'($urandom_range(0, 8) * 4);
        if (off == 32'h14) d = 32'($urandom_range(0, 12));
        if (off == 32'h10) d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12))
                                                          : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        if (off == 32'h18) d = (d & 32'hFFFFFFFC) | 32'($urandom_range(1, 3));
        a = 32'hFFFFFF00 | off | 32'($urandom_range(0, 3));
        drive(a, d, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);
      end else if (r < 99) begin
        case ($urandom_range(0, 3))
          0: a = 32'h00000100;
          1: a = 32'h80000000 | 32'($urandom_range(0, 255));
          2: a = 32'hFFFFFE00 | 32'($urandom_range(0, 255));
          default: a = 32'hFFFFFF20 | 32'($urandom_range(0, 223));
        endcase
        drive(a, d, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);
      end else begin
        drive(32'hFFFFFF00, d, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'h0);
      end
    end

    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
